// File: rtl/datapath_mc.sv
`default_nettype none
// ============================================================================
// datapath_mc : register file, encoded-select bus, HI/LO/PC/MDR/INPORT/Y and
//               a multi-cycle ALU (shift-add MUL, restoring DIV) writing Z.
// Rev 1.0
// ============================================================================
module datapath_mc #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int SELW  = $clog2(NREGS + 8)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [SELW-1:0]      bus_sel,
    input  logic [NREGS-1:0]     reg_in,
    input  logic                 hi_in,
    input  logic                 lo_in,
    input  logic                 pc_in,
    input  logic                 y_in,
    input  logic                 mdr_in,
    input  logic                 read_mdr,
    input  logic [WIDTH-1:0]     mdatain,
    input  logic                 inport_in,
    input  logic [WIDTH-1:0]     inport_data,
    input  logic [WIDTH-1:0]     c_data,
    input  logic [3:0]           alu_op,
    input  logic                 alu_start,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [WIDTH-1:0]     bus_out,
    output logic [2*WIDTH-1:0]   z_out,
    output logic [WIDTH-1:0]     y_out,
    output logic [WIDTH-1:0]     pc_out,
    output logic [WIDTH-1:0]     mdr_out
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [SELW-1:0] SEL_BASE = SELW'(NREGS);
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        DIV_ITER = 2'd2,
        FIX      = 2'd3
    } state_t;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] hi, lo, pc, mdr, inport, y, zhi, zlo;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             neg_q, neg_r, op_div;
    logic             start_ok;

    // ------------------------------------------------------------------ bus
    logic [SELW-1:0] sel_off;
    always_comb begin
        sel_off = bus_sel - SEL_BASE;
        bus_out = '0;
        if (bus_sel < SEL_BASE) begin
            bus_out = regs[bus_sel[RIW-1:0]];
        end else begin
            case (sel_off)
                SELW'(0): bus_out = hi;
                SELW'(1): bus_out = lo;
                SELW'(2): bus_out = zhi;
                SELW'(3): bus_out = zlo;
                SELW'(4): bus_out = pc;
                SELW'(5): bus_out = mdr;
                SELW'(6): bus_out = inport;
                SELW'(7): bus_out = c_data;
                default:  bus_out = '0;
            endcase
        end
    end

    // --------------------------------------------------------- storage regs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            hi     <= '0;
            lo     <= '0;
            pc     <= '0;
            mdr    <= '0;
            inport <= '0;
            y      <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_in[i]) regs[i] <= bus_out;
            end
            if (hi_in)     hi     <= bus_out;
            if (lo_in)     lo     <= bus_out;
            if (pc_in)     pc     <= bus_out;
            if (y_in)      y      <= bus_out;
            if (mdr_in)    mdr    <= read_mdr ? mdatain : bus_out;
            if (inport_in) inport <= inport_data;
        end
    end

    // ------------------------------------------------- single-cycle results
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] ror_t, rol_t;
    logic [WIDTH-1:0]   alu_res;
    always_comb begin
        shamt   = bus_out[SHW-1:0];
        ror_t   = {y, y} >> shamt;
        rol_t   = {y, y} << shamt;
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = y + bus_out;
            4'd1:    alu_res = y - bus_out;
            4'd2:    alu_res = y & bus_out;
            4'd3:    alu_res = y | bus_out;
            4'd4:    alu_res = ~bus_out;
            4'd5:    alu_res = -bus_out;
            4'd6:    alu_res = y >> shamt;
            4'd7:    alu_res = $signed(y) >>> shamt;
            4'd8:    alu_res = y << shamt;
            4'd9:    alu_res = ror_t[WIDTH-1:0];
            4'd10:   alu_res = rol_t[2*WIDTH-1:WIDTH];
            default: alu_res = '0;
        endcase
    end

    // --------------------------------------------- iterative step datapath
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    always_comb begin
        a_mag     = y[WIDTH-1] ? -y : y;
        b_mag     = bus_out[WIDTH-1] ? -bus_out : bus_out;
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? -prod : prod;
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        case (state)
            IDLE: begin
                if (alu_start) begin
                    start_ok = 1'b1;
                    if (alu_op == OP_MUL)
                        state_nx = MUL_ITER;
                    else if (alu_op == OP_DIV && bus_out != '0)
                        state_nx = DIV_ITER;
                end
            end
            MUL_ITER, DIV_ITER: if (cnt == CW'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_div   <= 1'b0;
            zhi      <= '0;
            zlo      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        div_zero <= 1'b0;
                        op_div   <= (alu_op == OP_DIV);
                        neg_q    <= y[WIDTH-1] ^ bus_out[WIDTH-1];
                        neg_r    <= y[WIDTH-1];
                        cnt      <= CW'(WIDTH);
                        acc_hi   <= '0;
                        if (alu_op == OP_MUL) begin
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                        end else if (alu_op == OP_DIV) begin
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                            // divide by zero resolves immediately
                            if (bus_out == '0) begin
                                zlo      <= '1;
                                zhi      <= y;
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                            end
                        end else begin
                            zlo  <= alu_res;
                            zhi  <= '0;
                            done <= 1'b1;
                        end
                    end
                end
                MUL_ITER: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt - 1'b1;
                end
                DIV_ITER: begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (op_div) begin
                        zlo <= neg_q ? -acc_lo : acc_lo;
                        zhi <= neg_r ? -acc_hi : acc_hi;
                    end else begin
                        {zhi, zlo} <= prod_fix;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign z_out   = {zhi, zlo};
    assign y_out   = y;
    assign pc_out  = pc;
    assign mdr_out = mdr;

endmodule
`default_nettype wire
